// File: rtl/dmem_byte_sequencer_if.sv
// ----------------------------------------------------------------------------
// dmem_byte_sequencer_if
//
// Request/response bus between the pipeline MEM stage (master) and the
// byte sequencer (slave).
//
// Signals:
//   req_valid   master->slave  request strobe, held until accepted
//   req_write   master->slave  1 = store, 0 = load
//   req_funct3  master->slave  RV64 funct3 size/sign code
//   req_addr    master->slave  byte address of the least-significant byte
//   req_wdata   master->slave  store data (low bytes used)
//   busy        slave->master  sequencer not idle; stall the pipeline
//   done        slave->master  one-cycle completion pulse
//   err         slave->master  access illegal / out of range (valid with done)
//   rdata       slave->master  extended load result
// ----------------------------------------------------------------------------
interface dmem_byte_sequencer_if #(
    parameter int ADDR_W = 64
) ();
    logic              req_valid;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [63:0]       rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/dmem_byte_sequencer.sv
// ----------------------------------------------------------------------------
// dmem_byte_sequencer
//
// Converts one RV64 load/store request into a little-endian sequence of
// single-byte memory cycles (one byte per clock) against a byte-wide memory
// with combinational read and posedge write. Handles sizing, sign/zero
// extension and bounds checking; busy stalls the pipeline until done.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      asynchronous active-low reset
//   req        request/response bus (slave side)
//   mem_addr   byte address to the memory
//   mem_wdata  byte to write
//   mem_we     byte write enable
//   mem_re     byte read enable
//   mem_rdata  byte read from memory (combinational from mem_addr)
// ----------------------------------------------------------------------------
module dmem_byte_sequencer #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_byte_sequencer_if.slave  req,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       buf_q;
    logic [2:0]        k;
    logic [2:0]        last_k;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [63:0]       rdata_q;

    logic [3:0]        size_n;
    logic [2:0]        last_n;
    logic [ADDR_W-1:0] size_a;
    logic              out_of_range;
    logic              illegal;
    logic [2:0]        k_next;
    logic [63:0]       buf_next;

    assign req.busy  = busy_q;
    assign req.done  = done_q;
    assign req.err   = err_q;
    assign req.rdata = rdata_q;

    // Sign/zero extension of the assembled little-endian load value.
    function automatic logic [63:0] extend(input logic [2:0] f3, input logic [63:0] raw);
        logic [63:0] r;
        case (f3)
            3'b000:  r = {{56{raw[7]}},  raw[7:0]};
            3'b001:  r = {{48{raw[15]}}, raw[15:0]};
            3'b010:  r = {{32{raw[31]}}, raw[31:0]};
            3'b100:  r = {56'd0, raw[7:0]};
            3'b101:  r = {48'd0, raw[15:0]};
            3'b110:  r = {32'd0, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    always_comb begin
        size_n = 4'd1;
        last_n = 3'd0;
        case (req.req_funct3[1:0])
            2'b00: begin size_n = 4'd1; last_n = 3'd0; end
            2'b01: begin size_n = 4'd2; last_n = 3'd1; end
            2'b10: begin size_n = 4'd4; last_n = 3'd3; end
            default: begin size_n = 4'd8; last_n = 3'd7; end
        endcase
        size_a = ADDR_W'(size_n);
        // Written as N > LIMIT - addr so addr + N can never overflow; the
        // subtraction is only meaningful when addr < LIMIT, which the first
        // term guarantees.
        out_of_range = (req.req_addr >= MEM_LIMIT) || (size_a > (MEM_LIMIT - req.req_addr));
        illegal = (req.req_funct3 == 3'b111) ||
                  (req.req_write && req.req_funct3[2]) ||
                  out_of_range;
        k_next = k + 3'd1;
        // Buffer including the byte being read this cycle, so the final byte
        // is available for extension at the same edge it is captured.
        buf_next = buf_q;
        buf_next[{k, 3'b000} +: 8] = mem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
            k         <= 3'd0;
            last_k    <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (req.req_valid) begin
                        write_q  <= req.req_write;
                        funct3_q <= req.req_funct3;
                        addr_q   <= req.req_addr;
                        wdata_q  <= req.req_wdata;
                        buf_q    <= '0;
                        k        <= 3'd0;
                        last_k   <= last_n;
                        busy_q   <= 1'b1;
                        if (illegal) begin
                            // No memory cycles; report immediately.
                            state  <= DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                            if (!req.req_write) begin
                                rdata_q <= '0;
                            end
                        end else begin
                            // Present byte 0 during the first ACCESS cycle.
                            state     <= ACCESS;
                            mem_addr  <= req.req_addr;
                            mem_wdata <= req.req_wdata[7:0];
                            mem_we    <= req.req_write;
                            mem_re    <= !req.req_write;
                        end
                    end
                end

                ACCESS: begin
                    if (!write_q) begin
                        buf_q <= buf_next;
                    end
                    if (k == last_k) begin
                        state  <= DONE;
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= 1'b0;
                        if (!write_q) begin
                            rdata_q <= extend(funct3_q, buf_next);
                        end
                    end else begin
                        k         <= k_next;
                        mem_addr  <= addr_q + ADDR_W'(k_next);
                        mem_wdata <= wdata_q[{k_next, 3'b000} +: 8];
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_byte_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dmem_byte_sequencer
//
// Directed testbench: a 64-byte memory model sits on the memory side, a
// logger records every byte cycle, and scenario tasks compare against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_dmem_byte_sequencer;

    localparam int MEM_BYTES = 64;
    localparam int ADDR_W    = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_byte_sequencer_if #(.ADDR_W(ADDR_W)) req_if ();

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic              mem_re;

    dmem_byte_sequencer #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req_if.slave),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // Memory model with a side port for preloading.
    logic [7:0] mem [MEM_BYTES];
    logic       pre_we = 1'b0;
    logic [5:0] pre_addr = 6'd0;
    logic [7:0] pre_data = 8'd0;

    assign mem_rdata = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    // Byte-cycle log.
    logic [ADDR_W-1:0] log_addr [$];
    logic [7:0]        log_data [$];
    logic              log_we   [$];

    always @(posedge clk) begin
        if (reset && (mem_we || mem_re)) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_we.push_back(mem_we);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic preload(input int a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a[5:0];
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Issues one request and returns the cycle (counted from the accept edge)
    // in which done was seen, or -1 on timeout.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, output int cyc);
        logic got;
        got = 1'b0;
        @(negedge clk);
        req_if.req_write  = w;
        req_if.req_funct3 = f3;
        req_if.req_addr   = a;
        req_if.req_wdata  = wd;
        req_if.req_valid  = 1'b1;
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            cyc++;
            got = req_if.done;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL req_timeout: done not seen within %0d cycles (addr %0h)", cyc, a);
            cyc = -1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({req_if.busy, req_if.done, req_if.err, mem_we, mem_re} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/err/we/re = %b, expected 00000",
                     {req_if.busy, req_if.done, req_if.err, mem_we, mem_re});
        end
        checks++;
        if (req_if.rdata !== 64'd0 || mem_addr !== 64'd0 || mem_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%0h mem_addr=%0h mem_wdata=%0h, expected 0",
                     req_if.rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_load_dword();
        int cyc;
        int n0;
        preload(0, 8'h64);
        n0 = log_addr.size();
        run_req(1'b0, 3'b011, 64'd0, 64'd0, cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL ld0_latency: done at cycle %0d, expected 9", cyc);
        end
        checks++;
        if (req_if.rdata !== 64'h64 || req_if.err !== 1'b0) begin
            errors++;
            $display("FAIL ld0_data: rdata=%0h err=%b, expected 64 err=0", req_if.rdata, req_if.err);
        end
        checks++;
        if (log_addr.size() - n0 !== 8) begin
            errors++;
            $display("FAIL ld0_count: %0d byte cycles, expected 8", log_addr.size() - n0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_addr[n0+i] !== 64'(i) || log_we[n0+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL ld0_cycle%0d: addr=%0h we=%b, expected addr=%0h read",
                             i, log_addr[n0+i], log_we[n0+i], i);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (req_if.done !== 1'b0 || req_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL ld0_after: done=%b busy=%b, expected 0 0", req_if.done, req_if.busy);
        end
    endtask

    task automatic test_store_dword();
        int cyc;
        int n0;
        logic [7:0] exp_b [8];
        exp_b = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        n0 = log_addr.size();
        run_req(1'b1, 3'b011, 64'd8, 64'h1122334455667788, cyc);
        checks++;
        if (cyc !== 9 || req_if.err !== 1'b0) begin
            errors++;
            $display("FAIL sd8_done: cycle %0d err=%b, expected 9 err=0", cyc, req_if.err);
        end
        checks++;
        if (req_if.rdata !== 64'h64) begin
            errors++;
            $display("FAIL sd8_rdata_hold: rdata=%0h, expected 64", req_if.rdata);
        end
        checks++;
        if (log_addr.size() - n0 !== 8) begin
            errors++;
            $display("FAIL sd8_count: %0d byte cycles, expected 8", log_addr.size() - n0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_addr[n0+i] !== 64'(8 + i) || log_data[n0+i] !== exp_b[i] ||
                    log_we[n0+i] !== 1'b1) begin
                    errors++;
                    $display("FAIL sd8_byte%0d: addr=%0h data=%0h we=%b, expected addr=%0h data=%0h write",
                             i, log_addr[n0+i], log_data[n0+i], log_we[n0+i], 8 + i, exp_b[i]);
                end
            end
        end
        run_req(1'b0, 3'b011, 64'd8, 64'd0, cyc);
        checks++;
        if (req_if.rdata !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL ld8_data: rdata=%0h, expected 1122334455667788", req_if.rdata);
        end
    endtask

    task automatic test_extend();
        int cyc;
        preload(16, 8'hF0);
        preload(17, 8'h80);
        run_req(1'b0, 3'b000, 64'd16, 64'd0, cyc);
        checks++;
        if (req_if.rdata !== 64'hFFFFFFFFFFFFFFF0 || cyc !== 2) begin
            errors++;
            $display("FAIL lb16: rdata=%0h cycle %0d, expected FFFFFFFFFFFFFFF0 cycle 2", req_if.rdata, cyc);
        end
        run_req(1'b0, 3'b100, 64'd16, 64'd0, cyc);
        checks++;
        if (req_if.rdata !== 64'h00000000000000F0) begin
            errors++;
            $display("FAIL lbu16: rdata=%0h, expected F0", req_if.rdata);
        end
        run_req(1'b0, 3'b001, 64'd16, 64'd0, cyc);
        checks++;
        if (req_if.rdata !== 64'hFFFFFFFFFFFF80F0 || cyc !== 3) begin
            errors++;
            $display("FAIL lh16: rdata=%0h cycle %0d, expected FFFFFFFFFFFF80F0 cycle 3", req_if.rdata, cyc);
        end
        run_req(1'b0, 3'b101, 64'd16, 64'd0, cyc);
        checks++;
        if (req_if.rdata !== 64'h00000000000080F0) begin
            errors++;
            $display("FAIL lhu16: rdata=%0h, expected 80F0", req_if.rdata);
        end
    endtask

    task automatic test_errors();
        int cyc;
        int n0;
        preload(63, 8'h5A);
        n0 = log_addr.size();
        run_req(1'b0, 3'b011, 64'd60, 64'd0, cyc);
        checks++;
        if (cyc !== 1 || req_if.err !== 1'b1 || req_if.rdata !== 64'd0) begin
            errors++;
            $display("FAIL ld60: cycle %0d err=%b rdata=%0h, expected cycle 1 err=1 rdata=0",
                     cyc, req_if.err, req_if.rdata);
        end
        run_req(1'b1, 3'b010, 64'd63, 64'hDEADBEEF, cyc);
        checks++;
        if (cyc !== 1 || req_if.err !== 1'b1) begin
            errors++;
            $display("FAIL sw63: cycle %0d err=%b, expected cycle 1 err=1", cyc, req_if.err);
        end
        run_req(1'b0, 3'b111, 64'd0, 64'd0, cyc);
        checks++;
        if (req_if.err !== 1'b1) begin
            errors++;
            $display("FAIL f3_111: err=%b, expected 1", req_if.err);
        end
        run_req(1'b1, 3'b100, 64'd0, 64'd0, cyc);
        checks++;
        if (req_if.err !== 1'b1) begin
            errors++;
            $display("FAIL store_unsigned: err=%b, expected 1", req_if.err);
        end
        run_req(1'b0, 3'b010, 64'hFFFFFFFFFFFFFFFC, 64'd0, cyc);
        checks++;
        if (req_if.err !== 1'b1 || cyc !== 1) begin
            errors++;
            $display("FAIL lw_huge_addr: err=%b cycle %0d, expected err=1 cycle 1", req_if.err, cyc);
        end
        checks++;
        if (log_addr.size() !== n0 || mem[63] !== 8'h5A) begin
            errors++;
            $display("FAIL err_no_access: %0d byte cycles mem[63]=%0h, expected 0 cycles mem[63]=5A",
                     log_addr.size() - n0, mem[63]);
        end
        run_req(1'b0, 3'b011, 64'd56, 64'd0, cyc);
        checks++;
        if (req_if.err !== 1'b0 || cyc !== 9) begin
            errors++;
            $display("FAIL ld56_edge: err=%b cycle %0d, expected err=0 cycle 9", req_if.err, cyc);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        req_if.req_write  = 1'b1;
        req_if.req_funct3 = 3'b011;
        req_if.req_addr   = 64'd24;
        req_if.req_wdata  = 64'hA1A2A3A4A5A6A7A8;
        req_if.req_valid  = 1'b1;
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req_if.busy, req_if.done, mem_we, mem_re} !== 4'b0 || mem_addr !== 64'd0 ||
            mem_wdata !== 8'd0) begin
            errors++;
            $display("FAIL midrst_outputs: busy/done/we/re=%b mem_addr=%0h mem_wdata=%0h, expected 0",
                     {req_if.busy, req_if.done, mem_we, mem_re}, mem_addr, mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (req_if.done !== 1'b0 || req_if.busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_idle%0d: done=%b busy=%b, expected 0 0", i, req_if.done, req_if.busy);
            end
        end
        checks++;
        if (mem[24] !== 8'hA8 || mem[25] !== 8'hA7 || mem[26] !== 8'hA6) begin
            errors++;
            $display("FAIL midrst_written: mem[24..26]=%0h %0h %0h, expected A8 A7 A6",
                     mem[24], mem[25], mem[26]);
        end
        for (int i = 27; i < 32; i++) begin
            checks++;
            if (mem[i] !== 8'h00) begin
                errors++;
                $display("FAIL midrst_untouched%0d: mem=%0h, expected 00", i, mem[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        logic exp_done;
        preload(32, 8'h78);
        preload(33, 8'h56);
        preload(34, 8'h34);
        preload(35, 8'h12);
        @(negedge clk);
        req_if.req_write  = 1'b0;
        req_if.req_funct3 = 3'b010;
        req_if.req_addr   = 64'd32;
        req_if.req_wdata  = 64'd0;
        req_if.req_valid  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            exp_busy = (c != 6);
            exp_done = (c == 5 || c == 11);
            checks++;
            if (req_if.busy !== exp_busy || req_if.done !== exp_done) begin
                errors++;
                $display("FAIL b2b_cycle%0d: busy=%b done=%b, expected busy=%b done=%b",
                         c, req_if.busy, req_if.done, exp_busy, exp_done);
            end
        end
        req_if.req_valid = 1'b0;
        checks++;
        if (req_if.rdata !== 64'h0000000012345678) begin
            errors++;
            $display("FAIL b2b_rdata: rdata=%0h, expected 12345678", req_if.rdata);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release: busy=%b, expected 0", req_if.busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_if.req_valid  = 1'b0;
        req_if.req_write  = 1'b0;
        req_if.req_funct3 = 3'b000;
        req_if.req_addr   = '0;
        req_if.req_wdata  = '0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) preload(i, 8'h00);
        test_load_dword();
        test_store_dword();
        test_extend();
        test_errors();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_byte_sequencer.md
Name: dmem_byte_sequencer

Overview:
- Sits between the pipeline MEM stage and the byte-addressed data memory array (8-bit word, MEM_BYTES entries, combinational read, write on posedge clk).
- Turns one RV64 load or store request into a sequence of single-byte memory cycles, one byte per clock, little-endian.
- Handles sub-word sizing, sign/zero extension and bounds checking.
- Raises busy so the hazard unit stalls the pipeline until done.

Parameters:
- MEM_BYTES, 64: number of bytes in the attached memory. Valid addresses are 0..MEM_BYTES-1.
- ADDR_W, 64: address width on both the request and memory sides.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request strobe; sampled only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 funct3 size/sign code.
- req_addr  in  ADDR_W  byte address of the least-significant byte.
- req_wdata  in  64  store data; the low bytes are used.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the access completes.
- err  out  1  valid while done=1: the access was illegal or out of range.
- rdata  out  64  load result, extended to 64 bits.
- mem_addr  out  ADDR_W  byte address to the memory.
- mem_wdata  out  8  byte to write.
- mem_we  out  1  byte write enable.
- mem_re  out  1  byte read enable.
- mem_rdata  in  8  byte read from the memory, combinational from mem_addr.

Behaviour:
- Reset: asynchronous to IDLE. busy, done, err, mem_we and mem_re are 0. rdata, mem_addr and mem_wdata are 0. Byte counter is 0.
- Reset mid-access aborts immediately. Bytes already written stay in memory; no done pulse is produced.
- States: IDLE, ACCESS, DONE.
- IDLE, when req_valid=1: latch write, funct3, addr and wdata. Size N is 1, 2, 4 or 8, taken from funct3[1:0].
- Illegal requests, which go straight to DONE with err=1 and no memory cycles:
  - funct3 = 111;
  - store with funct3[2] = 1;
  - addr + N > MEM_BYTES, computed without overflow (addr >= MEM_BYTES also counts as illegal).
- Legal requests go to ACCESS with the counter k = 0.
- ACCESS, cycle k:
  - mem_addr = addr + k.
  - Store: mem_we = 1, mem_wdata = wdata[8k+7:8k].
  - Load: mem_re = 1, and mem_rdata is captured into buffer byte k at the clock edge.
  - Advance k. After k = N-1, go to DONE.
  - Outside ACCESS, mem_we and mem_re are 0.
- DONE, for one cycle:
  - done = 1.
  - err as decided at accept.
  - For a load, rdata is updated at DONE entry:
    - funct3 000 / 001 / 010: sign-extend from bit 7 / 15 / 31;
    - funct3 100 / 101 / 110: zero-extend;
    - funct3 011: 64-bit value as read;
    - err: rdata = 0.
  - Stores leave rdata unchanged.
  - Next state is IDLE.
- rdata holds its value until the next load completes.
- Latency, with accept on edge 0:
  - legal access: done is high during cycle N+1 (N memory cycles plus the DONE cycle);
  - error: done is high during cycle 1.
- Back-to-back: a new request is accepted only in IDLE, so there is a minimum of one IDLE cycle between done and the next accept. req_valid outside IDLE is ignored; the requester holds it until accepted.
- Misaligned addresses are legal, since byte granularity makes them so.
- Wrap-around past MEM_BYTES-1 never occurs because of the bounds check.
- busy is registered from state, with no combinational path from req_valid.

Test Plan:
- Preload bytes 0..7 = 64 00 00 00 00 00 00 00, then ld at addr 0 → eight mem_re cycles at addresses 0..7; done high on cycle 9; rdata = 0x64; err = 0.
- sd 0x1122334455667788 at addr 8, then ld at addr 8 → mem_wdata sequence 88 77 66 55 44 33 22 11 on addresses 8..15; ld returns 0x1122334455667788.
- Byte 16 = 0xF0:
  - lb at 16 → rdata = 0xFFFFFFFFFFFFFFF0;
  - lbu at 16 → 0x00000000000000F0;
  - lh with bytes 16..17 = F0 80 → 0xFFFFFFFFFFFF80F0.
- Out of range:
  - ld at addr 60 → no mem_re or mem_we; done on cycle 1; err = 1; rdata = 0;
  - sw at addr 63 → err = 1, memory unchanged;
  - funct3 = 111 → err = 1.
- Mid-access reset: start sd at addr 24 and assert reset after 3 ACCESS cycles → outputs 0 and state IDLE immediately (asynchronously); bytes 24..26 written, 27..31 unchanged; no done pulse.
- Hold req_valid high continuously for two consecutive lw requests → second accept occurs exactly one cycle after the first done; busy stays low only during that IDLE cycle.
